// File: rtl/wb_forward_source.sv
// wb_forward_source: EX/WB boundary register and forwarding-data producer.
// Holds loads in LOAD_WAIT (stalling the front end) until mem_ready or timeout.
module wb_forward_source #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RW,
  input  logic [4:0]       DA,
  input  logic [1:0]       MD,
  input  logic [WIDTH-1:0] F,
  input  logic             status,
  input  logic [WIDTH-1:0] mem_data,
  input  logic             mem_ready,
  input  logic             flush,
  output logic             RW_1,
  output logic [4:0]       DA_1,
  output logic [WIDTH-1:0] BUS_D,
  output logic             wr_en,
  output logic             stall,
  output logic             mem_err
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic {
    RUN,
    LOAD_WAIT
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_nx;
  logic           is_load;
  logic           last;
  logic           tmo;
  logic [WIDTH-1:0] res;

  assign is_load = (MD == 2'b01) && !flush;
  assign last    = (cnt == CW'(TIMEOUT - 1));
  assign tmo     = (state == LOAD_WAIT) && !mem_ready && last;

  always_comb begin
    res = F;
    unique case (1'b1)
      (MD == 2'b01): res = '0;
      (MD == 2'b10): res = {{(WIDTH-1){1'b0}}, status};
      default:       res = F;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      RUN: begin
        if (is_load) begin
          state_nx = LOAD_WAIT;
          cnt_nx   = '0;
        end
      end
      LOAD_WAIT: begin
        if (mem_ready || last) state_nx = RUN;
        else                   cnt_nx   = cnt + 1'b1;
      end
      default: state_nx = RUN;
    endcase
  end

  always_comb begin
    stall = (state == LOAD_WAIT);
    wr_en = RW_1 && (DA_1 != 5'd0) && !stall;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RW_1    <= 1'b0;
      DA_1    <= '0;
      BUS_D   <= '0;
      mem_err <= 1'b0;
    end else begin
      mem_err <= tmo;
      if (state == RUN) begin
        RW_1  <= RW && !flush;
        DA_1  <= DA;
        BUS_D <= res;
      end else if (mem_ready) begin
        BUS_D <= mem_data;
      end else if (tmo) begin
        RW_1  <= 1'b0;
      end
    end
  end

endmodule
